regfile_dump_reader: RTL
========================

// Module: regfile_dump_reader
// PURPOSE
//  Debug-side reader for the 32x32 integer register file: on start, walks a register range
//  through one combinational read port and streams each value out on a valid/ready channel.
//  Sits beside the core datapath, sharing the regfile read port only while the core is halted.
//  Used by the debug/trace path and by benches to dump architectural state.
// PARAMETERS
//  DATA_W         32  width of one register / output word
//  ADDR_W         5   register index width; register count is 2**ADDR_W
//  FORCE_X0_ZERO  1   1: index 0 is always emitted as 0, regardless of rf_rdata
// PORTS
//  clk        in   1       rising-edge clock
//  reset      in   1       asynchronous, active-high reset
//  start      in   1       request a dump; sampled only in IDLE
//  first_reg  in   ADDR_W  first index to dump; latched with start
//  last_reg   in   ADDR_W  last index to dump; latched with start
//  abort      in   1       cancel the dump in progress
//  rf_raddr   out  ADDR_W  read address to the register file read port
//  rf_rdata   in   DATA_W  combinational read data for rf_raddr
//  out_valid  out  1       out_data/out_index/out_last are valid
//  out_ready  in   1       consumer accepts the word when out_valid & out_ready
//  out_data   out  DATA_W  register value
//  out_index  out  ADDR_W  index of out_data
//  out_last   out  1       this word is the final word of the dump
//  busy       out  1       high in any state other than IDLE
//  done       out  1       one-cycle pulse after the last word is accepted
// BEHAVIOUR
//  - Reset (async): state=IDLE; rf_raddr, out_data, out_index=0; out_valid, out_last,
//    busy, done=0. Reset mid-dump discards the dump; no done pulse is produced.
//  - FSM states:
//    - IDLE: start=1 latches first_reg into cur and last_reg into end; goes to READ.
//    - READ: rf_raddr=cur. At the next edge, capture out_data (0 if cur==0 and
//      FORCE_X0_ZERO), out_index=cur, out_last=(cur==end); goes to SEND.
//    - SEND: out_valid=1. out_data, out_index and out_last hold stable until the handshake.
//      - Handshake, out_last=0: cur=cur+1 mod 2**ADDR_W; goes to READ.
//      - Handshake, out_last=1: done=1 for one cycle; goes to IDLE.
//  - rf_raddr holds cur in READ and SEND; it holds the last value in IDLE.
//  - Latency: start at edge N gives out_valid=1 after edge N+1. Each accepted word costs
//    one bubble cycle, so peak throughput is 1 word per 2 cycles.
//  - Range rule: the walk always increments with wrap-around.
//    - first<=last dumps first..last.
//    - first>last dumps first..(2**ADDR_W-1), then 0..last.
//    - first==last dumps exactly one word.
//  - start while busy is ignored; first_reg and last_reg are don't-care outside IDLE start.
//  - abort: takes effect at the next edge from READ or SEND. State goes to IDLE,
//    out_valid=0, out_last=0, and no done pulse. A handshake in the same cycle as abort
//    counts as accepted, but abort still wins: no done, even if the word had out_last=1.
//  - start and abort together in IDLE: abort wins; the FSM stays in IDLE.
//  - done is never asserted together with out_valid.
// TESTING
//  - Full dump: preload x1..x31 = 0x100+i, start with first=0, last=31, out_ready=1.
//    -> 32 words; index 0 has data 0, index 5 has data 0x105; out_last only on index 31;
//       done pulse one cycle after that handshake.
//  - Backpressure: first=3, last=4, out_ready low for 5 cycles on word 3.
//    -> out_data/out_index hold 0x103/3 stable; word 4 follows; done=1 once.
//  - Wrap range: first=30, last=1.
//    -> indices 30,31,0,1 in order; out_last on 1.
//  - Single word and ignored start: first=last=7, with start re-pulsed while busy.
//    -> exactly one word (index 7), one done, no second dump.
//  - Abort: abort asserted during SEND of word 2 of 0..31.
//    -> out_valid=0 next cycle, no done, busy=0; a new start works normally afterwards.
//  - Async reset mid-dump: assert reset between clock edges while in SEND.
//    -> all outputs 0 immediately; state IDLE after release.

Source files
------------

// File: rtl/regfile_dump_reader.sv
// Debug-side register file dumper: walks an index range through one combinational read port
// and streams each value out on a valid/ready channel, one word per two cycles at best.
module regfile_dump_reader #(
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned ADDR_W        = 5,
  parameter bit          FORCE_X0_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W-1:0] last_reg,
  input  logic              abort,
  output logic [ADDR_W-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {StIdle, StRead, StSend} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] cur_q;
  logic [ADDR_W-1:0] end_q;
  logic [ADDR_W-1:0] cur_inc;
  logic              zero_word;

  assign cur_inc   = cur_q + ADDR_W'(1);
  assign zero_word = FORCE_X0_ZERO && (cur_q == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cur_q     <= '0;
      end_q     <= '0;
      rf_raddr  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // abort beats a simultaneous start
          if (start && !abort) begin
            cur_q    <= first_reg;
            end_q    <= last_reg;
            rf_raddr <= first_reg;
            busy     <= 1'b1;
            state_q  <= StRead;
          end
        end
        StRead: begin
          if (abort) begin
            busy    <= 1'b0;
            state_q <= StIdle;
          end else begin
            out_data  <= zero_word ? '0 : rf_rdata;
            out_index <= cur_q;
            out_last  <= (cur_q == end_q);
            out_valid <= 1'b1;
            state_q   <= StSend;
          end
        end
        StSend: begin
          if (abort) begin
            // an accepted word in this cycle still gets no done pulse
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            state_q   <= StIdle;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            if (out_last) begin
              out_last <= 1'b0;
              done     <= 1'b1;
              busy     <= 1'b0;
              state_q  <= StIdle;
            end else begin
              cur_q    <= cur_inc;
              rf_raddr <= cur_inc;
              state_q  <= StRead;
            end
          end
        end
        default: begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          busy      <= 1'b0;
          state_q   <= StIdle;
        end
      endcase
    end
  end

endmodule
